bpsk_rx_sequencer: RTL and testbench
====================================

// Module: bpsk_rx_sequencer
// PURPOSE
//  Controller for the BPSK symbol demodulator: drives its sine-table phase index and integrate-and-dump strobe,
//  collects the per-symbol guess bits, hunts for the sync word, then assembles a fixed-length frame into bytes
//  delivered over a valid/ready port. Sits between the demodulator datapath and the byte-level packet consumer.
// PARAMETERS
//  WAVELENGTH   16      samples per symbol (phase counts 0..WAVELENGTH-1); >=2
//  PHASE_W      16      width of phase index to sine table
//  SYNC_WORD    8'hD3   sync pattern, first received bit = MSB
//  FRAME_BYTES  4       payload bytes per frame after sync; >=1
// PORTS
//  clock        in   1        system clock, all logic on rising edge
//  reset_n      in   1        asynchronous active-low reset
//  enable       in   1        run sequencer; low = idle, phase parked
//  guess        in   1        symbol decision from demodulator
//  guess_valid  in   1        guess qualifier, one-cycle pulse per symbol
//  phase        out  PHASE_W  sine-table index to demodulator
//  dump         out  1        end-of-symbol strobe: demodulator decides and clears its sum
//  out_data     out  8        assembled payload byte, MSB first
//  out_valid    out  1        out_data valid; held until accepted
//  out_ready    in   1        consumer accepts out_data when out_valid && out_ready
//  frame_done   out  1        one-cycle pulse when last byte of frame is assembled
//  locked       out  1        high while in FRAME state
//  inverted     out  1        frame received with inverted polarity (optional feature)
//  overflow     out  1        sticky: a byte was dropped due to backpressure
//  clear_ovf    in   1        synchronous clear of overflow
// BEHAVIOUR
//  Reset: phase=0, dump=0, out_data=0, out_valid=0, frame_done=0, locked=0, inverted=0, overflow=0, state=IDLE,
//   shift reg=0, bit/byte counters=0. Reset mid-frame discards all partial data immediately.
//  Phase: while enable, phase increments each cycle; at phase==WAVELENGTH-1, dump=1 for that cycle and phase wraps
//   to 0 on the next edge. enable low: phase forced to 0, dump=0.
//  States: IDLE -> HUNT when enable=1. Any state -> IDLE when enable=0 (partial byte/frame discarded, locked=0;
//   pending out_valid byte kept and still handshaken). guess_valid ignored in IDLE.
//  HUNT: on guess_valid, sr <= {sr[6:0], guess}. If new sr==SYNC_WORD -> FRAME, inverted=0, bit/byte counters=0.
//  FRAME: locked=1; on guess_valid, shift (guess ^ inverted) into byte reg MSB first; on 8th bit, the byte is
//   offered to output next cycle (latency: 8th guess_valid -> out_valid 1 cycle later). byte_cnt+1.
//   After byte FRAME_BYTES: frame_done=1 for one cycle (same cycle out_valid rises), sr cleared, -> HUNT.
//  Output: out_valid/out_data stable until out_ready. New byte completes while out_valid && !out_ready: byte dropped,
//   old byte kept, overflow<=1. Same-cycle out_ready and new byte: new byte loads, out_valid stays 1, no overflow.
//   Dropped last byte still counts toward frame end (frame_done still pulses).
//  overflow: sticky; clear_ovf=1 clears it; a simultaneous drop event wins (overflow stays 1).
//  guess_valid coinciding with state exit to IDLE is discarded. Counters never wrap: bit 0..7, byte 0..FRAME_BYTES-1.
// CONFIGURATION
//  BPSK_SEQ_POLARITY_EN defined: in HUNT, new sr==~SYNC_WORD also enters FRAME with inverted=1, and all payload
//   bits are XOR-inverted (resolves BPSK 180-degree ambiguity); true match has priority.
//  Not defined: only SYNC_WORD matches; inverted tied 0; ~SYNC_WORD never locks.
// TESTING
//  1 WAVELENGTH=16, enable 1 for 40 cycles -> dump at cycles 15,31; phase 0..15 repeating; enable 0 -> phase=0.
//  2 bits 1101_0011 then A5,3C,FF,00 with out_ready=1 -> locked, out_data A5,3C,FF,00, frame_done with 00, back to HUNT.
//  3 as 2 but out_ready=0 throughout -> out_valid holds A5, overflow=1 after 2nd byte; clear_ovf -> overflow=0.
//  4 bits 0010_1100 then 5A: macro on -> inverted=1, out_data A5; macro off -> no lock, out_valid stays 0.
//  5 enable drop after 3 payload bits -> IDLE, locked=0, no byte out; re-enable + sync + A5.. -> A5 first.
//  6 reset_n low mid-frame with out_valid=1 -> all outputs to reset values asynchronously, no further bytes.

Source files
------------

// File: rtl/bpsk_rx_sequencer.sv
// rtl/bpsk_rx_sequencer.sv - BPSK demodulator controller: phase/dump timing, sync hunt, frame-to-byte assembly
//
// Drives the sine-table phase index and end-of-symbol dump strobe, shifts in symbol
// decisions, hunts for SYNC_WORD, then packs FRAME_BYTES payload bytes (MSB first)
// onto a valid/ready byte port.
//
// Optional feature macro: BPSK_SEQ_POLARITY_EN
//   defined   - the complement of SYNC_WORD also locks, with inverted=1 and payload bits
//               XOR-inverted (resolves the 180-degree BPSK ambiguity); true match wins.
//   undefined - only SYNC_WORD locks; inverted stays 0.
//
// Ports:
//   clock, reset_n          clock (rising edge), asynchronous active-low reset
//   enable                  run sequencer; low parks phase at 0 and returns FSM to IDLE
//   guess, guess_valid      symbol decision and its one-cycle qualifier
//   phase, dump             sine-table index and end-of-symbol strobe
//   out_data, out_valid,    assembled byte, held until out_ready
//   out_ready
//   frame_done              one-cycle pulse with the last byte of a frame
//   locked                  high while in FRAME
//   inverted                frame locked on complemented sync word
//   overflow, clear_ovf     sticky byte-drop flag and its synchronous clear

module bpsk_rx_sequencer #(
    parameter int          WAVELENGTH  = 16,
    parameter int          PHASE_W     = 16,
    parameter logic [7:0]  SYNC_WORD   = 8'hD3,
    parameter int          FRAME_BYTES = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               guess,
    input  logic               guess_valid,
    output logic [PHASE_W-1:0] phase,
    output logic               dump,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_done,
    output logic               locked,
    output logic               inverted,
    output logic               overflow,
    input  logic               clear_ovf
);

    localparam int                 BCW        = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(WAVELENGTH - 1);
    localparam logic [BCW-1:0]     BYTE_LAST  = BCW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HUNT  = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [7:0]         sr_q, sr_d;
    logic [7:0]         byte_q, byte_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               inverted_q, inverted_d;
    logic               overflow_q, overflow_d;

    logic [7:0]         sr_shift;
    logic [7:0]         new_byte;
    logic               byte_done;
    logic               drop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            sr_q         <= '0;
            byte_q       <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            inverted_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            sr_q         <= sr_d;
            byte_q       <= byte_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            inverted_q   <= inverted_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        byte_d       = byte_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        inverted_d   = inverted_q;
        overflow_d   = overflow_q;
        byte_done    = 1'b0;
        drop         = 1'b0;
        sr_shift     = {sr_q[6:0], guess};
        new_byte     = {byte_q[6:0], guess ^ inverted_q};

        if (!enable) begin
            phase_d = '0;
        end else if (phase_q == PHASE_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_HUNT;
                end
            end
            S_HUNT: begin
                if (guess_valid) begin
                    sr_d = sr_shift;
                    if (sr_shift == SYNC_WORD) begin
                        state_d    = S_FRAME;
                        inverted_d = 1'b0;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        byte_d     = '0;
                    end
`ifdef BPSK_SEQ_POLARITY_EN
                    else if (sr_shift == ~SYNC_WORD) begin
                        state_d    = S_FRAME;
                        inverted_d = 1'b1;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        byte_d     = '0;
                    end
`endif
                end
            end
            S_FRAME: begin
                if (guess_valid) begin
                    byte_d = new_byte;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        byte_done = 1'b1;
                        if (byte_cnt_q == BYTE_LAST) begin
                            // Frame complete: a dropped last byte still ends the frame.
                            byte_cnt_d   = '0;
                            frame_done_d = 1'b1;
                            sr_d         = '0;
                            byte_d       = '0;
                            state_d      = S_HUNT;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable overrides everything: a guess arriving on the exit cycle is lost,
        // but a byte already presented on the output stays until handshaken.
        if (!enable) begin
            state_d      = S_IDLE;
            sr_d         = '0;
            byte_d       = '0;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            frame_done_d = 1'b0;
            byte_done    = 1'b0;
        end

        if (byte_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = new_byte;
                out_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    assign phase      = enable ? phase_q : '0;
    assign dump       = enable && (phase_q == PHASE_LAST);
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign locked     = (state_q == S_FRAME);
    assign inverted   = inverted_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bpsk_rx_sequencer.sv
// tb/tb_bpsk_rx_sequencer.sv - self-checking bench for bpsk_rx_sequencer

module tb_bpsk_rx_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        guess = 1'b0;
    logic        guess_valid = 1'b0;
    logic [15:0] phase;
    logic        dump;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        frame_done;
    logic        locked;
    logic        inverted;
    logic        overflow;
    logic        clear_ovf = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    bpsk_rx_sequencer #(
        .WAVELENGTH (16),
        .PHASE_W    (16),
        .SYNC_WORD  (8'hD3),
        .FRAME_BYTES(4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .guess      (guess),
        .guess_valid(guess_valid),
        .phase      (phase),
        .dump       (dump),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .locked     (locked),
        .inverted   (inverted),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    typedef struct {
        logic [7:0] bits;
        logic       rdy;
        logic       clr;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_fd;
        logic       exp_locked;
        logic       exp_ovf;
        logic       exp_inv;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic rdy);
        for (int k = 0; k < n; k++) begin
            guess       = b[7-k];
            guess_valid = 1'b1;
            out_ready   = rdy;
            step();
        end
        guess_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{8'hD3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{8'hD3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef BPSK_SEQ_POLARITY_EN
        tbl[11] = '{8'h2C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        tbl[11] = '{8'h2C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // Reset values
        step();
        step();
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_dump", 32'(dump), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_inverted", 32'(inverted), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        reset_n = 1'b1;

        // Phase counter and dump strobe
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("phase_c%0d", i), 32'(phase), 32'(i % 16));
            chk($sformatf("dump_c%0d", i), 32'(dump), ((i % 16) == 15) ? 32'h1 : 32'h0);
            step();
        end
        enable = 1'b0;
        #1;
        chk("phase_disabled", 32'(phase), 32'h0);
        chk("dump_disabled", 32'(dump), 32'h0);
        step();
        chk("phase_disabled_edge", 32'(phase), 32'h0);

        // Byte-level vectors: frame, backpressure/overflow, clear, polarity
        enable = 1'b1;
        step();
        for (int r = 0; r < 13; r++) begin
            clear_ovf = tbl[r].clr;
            send_bits(tbl[r].bits, 8, tbl[r].rdy);
            clear_ovf = 1'b0;
            chk($sformatf("r%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].exp_valid));
            if (tbl[r].exp_valid)
                chk($sformatf("r%0d_out_data", r), 32'(out_data), 32'(tbl[r].exp_data));
            chk($sformatf("r%0d_frame_done", r), 32'(frame_done), 32'(tbl[r].exp_fd));
            chk($sformatf("r%0d_locked", r), 32'(locked), 32'(tbl[r].exp_locked));
            chk($sformatf("r%0d_overflow", r), 32'(overflow), 32'(tbl[r].exp_ovf));
            chk($sformatf("r%0d_inverted", r), 32'(inverted), 32'(tbl[r].exp_inv));
        end
        step();
        chk("frame_done_one_cycle", 32'(frame_done), 32'h0);

        // Enable drop mid-byte discards partial data
        out_ready   = 1'b1;
        enable      = 1'b0;
        guess       = 1'b1;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        chk("dis_locked", 32'(locked), 32'h0);
        chk("dis_out_valid", 32'(out_valid), 32'h0);
        enable = 1'b1;
        step();
        send_bits(8'hD3, 8, 1'b1);
        chk("s5_sync_locked", 32'(locked), 32'h1);
        chk("s5_sync_inverted", 32'(inverted), 32'h0);
        send_bits(8'hA5, 3, 1'b1);
        enable      = 1'b0;
        guess       = 1'b0;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        chk("s5_drop_locked", 32'(locked), 32'h0);
        chk("s5_drop_out_valid", 32'(out_valid), 32'h0);
        enable = 1'b1;
        step();
        send_bits(8'hD3, 8, 1'b0);
        chk("s5_relock", 32'(locked), 32'h1);
        send_bits(8'hA5, 7, 1'b0);
        chk("s5_no_early_byte", 32'(out_valid), 32'h0);
        send_bits(8'hA5 << 7, 1, 1'b0);
        chk("s5_first_valid", 32'(out_valid), 32'h1);
        chk("s5_first_data", 32'(out_data), 32'hA5);

        // Asynchronous reset mid-frame with a pending byte
        send_bits(8'h3C, 3, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("s6_out_valid", 32'(out_valid), 32'h0);
        chk("s6_out_data", 32'(out_data), 32'h0);
        chk("s6_locked", 32'(locked), 32'h0);
        chk("s6_phase", 32'(phase), 32'h0);
        chk("s6_overflow", 32'(overflow), 32'h0);
        chk("s6_frame_done", 32'(frame_done), 32'h0);
        step();
        reset_n = 1'b1;
        send_bits(8'h3C << 3, 5, 1'b0);
        send_bits(8'hFF, 8, 1'b0);
        chk("s6_no_byte_after", 32'(out_valid), 32'h0);
        chk("s6_not_locked_after", 32'(locked), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
